// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// RV32 funct3 codes, FSM states and the latched request bundle.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    ACC1,
    WAIT1,
    ACC2,
    WAIT2,
    DONE
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] wdata;
  } req_t;

  function automatic logic f3_legal(
    input logic       wr,
    input logic [2:0] f3
  );
    logic ok;
    case (f3)
      LB, LH, LW: ok = 1'b1;
      LBU, LHU:   ok = !wr;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit.
// Rotates store data into lanes and gathers/extends load bytes.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic        phase,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic        split,
  output logic [3:0]  be,
  output logic [31:0] wdata_al,
  output logic [31:0] ldata
);

  logic [3:0]  mask;
  logic [7:0]  be_wide;
  logic [5:0]  sh;
  logic [5:0]  sh_inv;
  logic [31:0] gath;

  always_comb begin
    mask = 4'b0001;
    case (funct3[1:0])
      2'd1:    mask = 4'b0011;
      2'd2:    mask = 4'b1111;
      default: mask = 4'b0001;
    endcase
  end

  assign be_wide = {4'b0000, mask} << offset;
  assign split   = |be_wide[7:4];
  assign be      = phase ? be_wide[7:4]
                         : be_wide[3:0];

  assign sh     = {1'b0, offset, 3'b000};
  assign sh_inv = 6'd32 - sh;

  // Shifts of 32 yield zero, so offset 0 needs no special case.
  assign wdata_al = (wdata << sh)
                  | (wdata >> sh_inv);
  assign gath     = (rdata_lo >> sh)
                  | (rdata_hi << sh_inv);

  always_comb begin
    ldata = gath;
    unique case (1'b1)
      funct3 == LB:
        ldata = {{24{gath[7]}}, gath[7:0]};
      funct3 == LH:
        ldata = {{16{gath[15]}}, gath[15:0]};
      funct3 == LBU:
        ldata = {24'h0, gath[7:0]};
      funct3 == LHU:
        ldata = {16'h0, gath[15:0]};
      default:
        ldata = gath;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time,
// misaligned accesses split over two consecutive words.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int WA = ADDR_W - 2;

  state_t            state;
  state_t            state_nx;
  req_t              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       rd0_q;
  logic [31:0]       rd1_q;

  logic              split;
  logic              phase;
  logic              acc;
  logic              legal;
  logic [3:0]        be;
  logic [31:0]       wal;
  logic [31:0]       ldata;
  logic [WA-1:0]     waddr;

  assign waddr = addr_q[ADDR_W-1:2];
  assign phase = (state == ACC2);
  assign acc   = (state == ACC1) || (state == ACC2);
  assign legal = f3_legal(req_q.wr, req_q.f3);

  lsu_lane_align u_align (
    .funct3   (req_q.f3),
    .offset   (addr_q[1:0]),
    .phase    (phase),
    .wdata    (req_q.wdata),
    .rdata_lo (rd0_q),
    .rdata_hi (rd1_q),
    .split    (split),
    .be       (be),
    .wdata_al (wal),
    .ldata    (ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_q  <= '0;
      addr_q <= '0;
      rd0_q  <= '0;
      rd1_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        req_q.wr    <= req_write;
        req_q.f3    <= req_funct3;
        req_q.wdata <= req_wdata;
        addr_q      <= req_addr;
      end
      if (state == WAIT1) rd0_q <= mem_rdata;
      if (state == WAIT2) rd1_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (req_valid)
          state_nx = f3_legal(req_write, req_funct3)
                   ? ACC1 : DONE;
      ACC1:
        if (!req_q.wr) state_nx = WAIT1;
        else           state_nx = split ? ACC2 : DONE;
      WAIT1:
        state_nx = split ? ACC2 : DONE;
      ACC2:
        state_nx = req_q.wr ? DONE : WAIT2;
      WAIT2:
        state_nx = DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    mem_en    = acc;
    mem_we    = acc && req_q.wr;
    mem_be    = acc ? be : 4'b0000;
    mem_wdata = acc ? wal : 32'h0;
    mem_addr  = '0;
    if (state == ACC1) mem_addr = waddr;
    if (state == ACC2) mem_addr = waddr + 1'b1;
    rsp_valid = (state == DONE);
    rsp_err   = (state == DONE) && !legal;
    rsp_rdata = 32'h0;
    if (state == DONE && legal && !req_q.wr)
      rsp_rdata = ldata;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-addressed memory model,
// per-feature tasks, response monitor popping an expected queue.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [13:0] req_addr = 14'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } strobe_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic [31:0] mem [0:4095];
  strobe_t     slog[$];
  rsp_t        exp_q[$];
  rsp_t        exp_r;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      slog.push_back(strobe_t'{mem_we, mem_addr,
                               mem_be, mem_wdata});
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b])
            mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b want none",
                 rsp_rdata, rsp_err);
      end else begin
        exp_r = exp_q.pop_front();
        if ({rsp_rdata, rsp_err} !== exp_r) begin
          failures++;
          $display("FAIL rsp_data: got rdata=%h err=%b want rdata=%h err=%b",
                   rsp_rdata, rsp_err, exp_r.rdata, exp_r.err);
        end
      end
    end
  end

  task automatic send(
    input  logic        w,
    input  logic [2:0]  f3,
    input  logic [13:0] a,
    input  logic [31:0] d,
    output int          lat
  );
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    if (!rsp_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_en, mem_we}
        !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 10000",
               {req_ready, rsp_valid, rsp_err, mem_en, mem_we});
    end
    checks++;
    if ({rsp_rdata, mem_be, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0",
               {rsp_rdata, mem_be, mem_addr, mem_wdata});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    int lat;
    slog.delete();
    exp_q.push_back(rsp_t'{32'h0, 1'b0});
    send(1'b1, SW, 14'h080, 32'hDEADBEEF, lat);
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL sw_latency: got %0d want 2", lat);
    end
    checks++;
    if (slog.size() != 1) begin
      failures++;
      $display("FAIL sw_strobes: got %0d want 1", slog.size());
    end else begin
      checks++;
      if (slog[0] !== strobe_t'{1'b1, 12'h020, 4'b1111,
                                32'hDEADBEEF}) begin
        failures++;
        $display("FAIL sw_strobe: got %h want %h", slog[0],
                 strobe_t'{1'b1, 12'h020, 4'b1111, 32'hDEADBEEF});
      end
    end
    exp_q.push_back(rsp_t'{32'hDEADBEEF, 1'b0});
    send(1'b0, LW, 14'h080, 32'h0, lat);
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL lw_latency: got %0d want 3", lat);
    end
  endtask

  task automatic test_byte();
    int lat;
    slog.delete();
    exp_q.push_back(rsp_t'{32'h0, 1'b0});
    send(1'b1, SB, 14'h087, 32'h00000080, lat);
    checks++;
    if (slog.size() != 1 || slog[0].addr !== 12'h021 ||
        slog[0].be !== 4'b1000 ||
        slog[0].data[31:24] !== 8'h80 || lat != 2) begin
      failures++;
      $display("FAIL sb_strobe: got n=%0d lat=%0d %h want 021/1000/80",
               slog.size(), lat, slog.size() > 0 ? slog[0] : '0);
    end
    exp_q.push_back(rsp_t'{32'hFFFFFF80, 1'b0});
    send(1'b0, LB, 14'h087, 32'h0, lat);
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL lb_latency: got %0d want 3", lat);
    end
    exp_q.push_back(rsp_t'{32'h00000080, 1'b0});
    send(1'b0, LBU, 14'h087, 32'h0, lat);
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL lbu_latency: got %0d want 3", lat);
    end
  endtask

  task automatic test_split_half();
    int lat;
    slog.delete();
    exp_q.push_back(rsp_t'{32'h0, 1'b0});
    send(1'b1, SH, 14'h083, 32'h0000A5C3, lat);
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL sh_latency: got %0d want 3", lat);
    end
    checks++;
    if (slog.size() != 2) begin
      failures++;
      $display("FAIL sh_strobes: got %0d want 2", slog.size());
    end else begin
      checks++;
      if (slog[0].we !== 1'b1 || slog[0].addr !== 12'h020 ||
          slog[0].be !== 4'b1000 ||
          slog[0].data[31:24] !== 8'hC3) begin
        failures++;
        $display("FAIL sh_first: got %h want 020/1000/C3", slog[0]);
      end
      checks++;
      if (slog[1].we !== 1'b1 || slog[1].addr !== 12'h021 ||
          slog[1].be !== 4'b0001 ||
          slog[1].data[7:0] !== 8'hA5) begin
        failures++;
        $display("FAIL sh_second: got %h want 021/0001/A5", slog[1]);
      end
    end
    exp_q.push_back(rsp_t'{32'hFFFFA5C3, 1'b0});
    send(1'b0, LH, 14'h083, 32'h0, lat);
    checks++;
    if (lat != 5) begin
      failures++;
      $display("FAIL lh_split_latency: got %0d want 5", lat);
    end
  endtask

  task automatic test_wrap();
    int lat;
    exp_q.push_back(rsp_t'{32'h0, 1'b0});
    send(1'b1, SW, 14'h3FFC, 32'h11223344, lat);
    exp_q.push_back(rsp_t'{32'h0, 1'b0});
    send(1'b1, SW, 14'h0000, 32'h55667788, lat);
    slog.delete();
    exp_q.push_back(rsp_t'{32'h77881122, 1'b0});
    send(1'b0, LW, 14'h3FFE, 32'h0, lat);
    checks++;
    if (lat != 5) begin
      failures++;
      $display("FAIL lw_wrap_latency: got %0d want 5", lat);
    end
    checks++;
    if (slog.size() != 2) begin
      failures++;
      $display("FAIL lw_wrap_strobes: got %0d want 2", slog.size());
    end else begin
      checks++;
      if ({slog[0].we, slog[0].addr, slog[0].be,
           slog[1].we, slog[1].addr, slog[1].be}
          !== {1'b0, 12'hFFF, 4'b1100, 1'b0, 12'h000, 4'b0011}) begin
        failures++;
        $display("FAIL lw_wrap_addr: got %h/%b %h/%b want FFF/1100 000/0011",
                 slog[0].addr, slog[0].be, slog[1].addr, slog[1].be);
      end
    end
  endtask

  task automatic test_error();
    int lat;
    slog.delete();
    exp_q.push_back(rsp_t'{32'h0, 1'b1});
    send(1'b1, 3'd3, 14'h100, 32'h12345678, lat);
    checks++;
    if (lat != 1) begin
      failures++;
      $display("FAIL err_store_latency: got %0d want 1", lat);
    end
    exp_q.push_back(rsp_t'{32'h0, 1'b1});
    send(1'b1, 3'd4, 14'h100, 32'h12345678, lat);
    checks++;
    if (lat != 1) begin
      failures++;
      $display("FAIL err_store4_latency: got %0d want 1", lat);
    end
    exp_q.push_back(rsp_t'{32'h0, 1'b1});
    send(1'b0, 3'd6, 14'h080, 32'h0, lat);
    checks++;
    if (lat != 1) begin
      failures++;
      $display("FAIL err_load_latency: got %0d want 1", lat);
    end
    checks++;
    if (slog.size() != 0) begin
      failures++;
      $display("FAIL err_no_access: got %0d strobes want 0",
               slog.size());
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int guard = 0;
    slog.delete();
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = LH;
    req_addr   = 14'h083;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_busy: got ready=%b want 0", req_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, mem_en, rsp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL mid_reset: got %b want 100",
               {req_ready, mem_en, rsp_valid});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (slog.size() != 1) begin
      failures++;
      $display("FAIL mid_strobes: got %0d want 1", slog.size());
    end
    // first edge after release must accept
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = LBU;
    req_addr   = 14'h087;
    exp_q.push_back(rsp_t'{32'h00000080, 1'b0});
    rst_n = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    checks++;
    if (lat != 3 || !rsp_valid) begin
      failures++;
      $display("FAIL first_accept: got lat=%0d want 3", lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int c0;
    exp_q.push_back(rsp_t'{32'hFFFFFF80, 1'b0});
    send(1'b0, LB, 14'h087, 32'h0, lat);
    c0 = cyc;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_ready: got %b want 0", req_ready);
    end
    exp_q.push_back(rsp_t'{32'h0000A5C3, 1'b0});
    send(1'b0, LHU, 14'h083, 32'h0, lat);
    checks++;
    if (cyc - c0 != 6 || lat != 5) begin
      failures++;
      $display("FAIL b2b_gap: got %0d cycles lat=%0d want 6 lat=5",
               cyc - c0, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_split_half();
    test_wrap();
    test_error();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rsp_missing: got %0d pending want 0",
               exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
